// File: rtl/splitter_tree_arrival_monitor.sv
// splitter_tree_arrival_monitor
// Watches the root event of the 8-leaf splitter tree and the leaf strobes.
// For each root event it collects which leaves fired, the first-to-last
// arrival skew and whether any leaf fired twice. It then holds a pass/fail
// result behind a valid/ready handshake.
//
// Ports:
//   clk        monitor clock
//   rst_n      asynchronous active-low reset
//   in_pulse   one-cycle root event
//   out_pulse  leaf arrival strobes, bit i = leaf i
//   res_valid  result available (held until res_ready)
//   res_ready  consumer accepts result
//   res_ok     pass flag: all leaves, skew <= MAX_SKEW, no duplicates
//   res_mask   leaves that fired
//   res_skew   last arrival minus first arrival (0 if nothing fired)
//   res_dup    some leaf pulsed more than once
//   overrun    sticky: root event seen while busy
//   spurious   sticky: leaf strobe seen while idle with no root event
//   err_count  saturating count of accepted failing results
//
// state   | meaning
// IDLE    | waiting for a root event
// COLLECT | timing leaf arrivals until all fired or TIMEOUT reached
// REPORT  | result held on res_* until handshake
module splitter_tree_arrival_monitor #(
  parameter int NUM_OUT  = 8,
  parameter int TIMEOUT  = 15,
  parameter int MAX_SKEW = 2,
  parameter int TW       = 4,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_pulse,
  input  logic [NUM_OUT-1:0] out_pulse,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_ok,
  output logic [NUM_OUT-1:0] res_mask,
  output logic [TW-1:0]      res_skew,
  output logic               res_dup,
  output logic               overrun,
  output logic               spurious,
  output logic [CNT_W-1:0]   err_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_t;

  localparam logic [NUM_OUT-1:0] ALL_ONES   = '1;
  localparam logic [TW-1:0]      TIMEOUT_T  = TW'(TIMEOUT);
  localparam logic [TW-1:0]      MAX_SKEW_T = TW'(MAX_SKEW);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [NUM_OUT-1:0] mask;
  logic               dup;
  logic               have_first;
  logic [TW-1:0]      first;
  logic [TW-1:0]      last;

  // Next-cycle collection values; these include the pulses sampled in the
  // current cycle, so the final COLLECT cycle is reflected in the result.
  logic [TW-1:0]      t_next;
  logic [NUM_OUT-1:0] mask_next;
  logic               arrival;
  logic               dup_next;
  logic               fired_next;
  logic [TW-1:0]      first_next;
  logic [TW-1:0]      last_next;
  logic [TW-1:0]      skew_next;
  logic               ok_next;
  logic               done_next;

  assign t_next     = timer + TW'(1);
  assign mask_next  = mask | out_pulse;
  assign arrival    = |out_pulse;
  assign dup_next   = dup | (|(out_pulse & mask));
  assign fired_next = have_first | arrival;
  assign first_next = (have_first || !arrival) ? first : t_next;
  assign last_next  = arrival ? t_next : last;
  assign skew_next  = fired_next ? (last_next - first_next) : '0;
  assign ok_next    = (mask_next == ALL_ONES) && (skew_next <= MAX_SKEW_T) && !dup_next;
  // Timeout check on t_next keeps the timer from ever wrapping.
  assign done_next  = (mask_next == ALL_ONES) || (t_next == TIMEOUT_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      mask       <= '0;
      dup        <= 1'b0;
      have_first <= 1'b0;
      first      <= '0;
      last       <= '0;
      res_valid  <= 1'b0;
      res_ok     <= 1'b0;
      res_mask   <= '0;
      res_skew   <= '0;
      res_dup    <= 1'b0;
      overrun    <= 1'b0;
      spurious   <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_pulse) begin
            state      <= COLLECT;
            timer      <= '0;
            mask       <= out_pulse;
            dup        <= 1'b0;
            have_first <= |out_pulse;
            first      <= '0;
            last       <= '0;
          end else if (|out_pulse) begin
            spurious <= 1'b1;
          end
        end

        COLLECT: begin
          if (in_pulse) overrun <= 1'b1;
          timer      <= t_next;
          mask       <= mask_next;
          dup        <= dup_next;
          have_first <= fired_next;
          first      <= first_next;
          last       <= last_next;
          if (done_next) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_mask  <= mask_next;
            res_skew  <= skew_next;
            res_dup   <= dup_next;
            res_ok    <= ok_next;
          end
        end

        REPORT: begin
          // A root event here is lost even if the handshake completes now.
          if (in_pulse) overrun <= 1'b1;
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            if (!res_ok && (err_count != CNT_MAX)) err_count <= err_count + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_splitter_tree_arrival_monitor.sv
module tb_splitter_tree_arrival_monitor;

  localparam int NUM_OUT  = 8;
  localparam int TIMEOUT  = 15;
  localparam int MAX_SKEW = 2;
  localparam int TW       = 4;
  localparam int CNT_W    = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_pulse = 1'b0;
  logic [NUM_OUT-1:0] out_pulse = '0;
  logic               res_ready = 1'b0;
  logic               res_valid;
  logic               res_ok;
  logic [NUM_OUT-1:0] res_mask;
  logic [TW-1:0]      res_skew;
  logic               res_dup;
  logic               overrun;
  logic               spurious;
  logic [CNT_W-1:0]   err_count;

  splitter_tree_arrival_monitor #(
    .NUM_OUT(NUM_OUT), .TIMEOUT(TIMEOUT), .MAX_SKEW(MAX_SKEW), .TW(TW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_pulse(in_pulse), .out_pulse(out_pulse),
    .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
    .res_mask(res_mask), .res_skew(res_skew), .res_dup(res_dup),
    .overrun(overrun), .spurious(spurious), .err_count(err_count)
  );

  typedef struct {
    logic [7:0] mask;
    int         skew;
    bit         dup;
    bit         ok;
    int         vcyc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         exp_err = 0;
  bit         prev_v = 1'b0;
  logic [7:0] sched[0:15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #800000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < 16; i++) sched[i] = 8'h00;
  endtask

  task automatic random_sched();
    int base, spread, t;
    clear_sched();
    base   = $urandom_range(0, 10);
    spread = $urandom_range(0, 4);
    for (int ch = 0; ch < NUM_OUT; ch++) begin
      if ($urandom_range(0, 9) != 0) begin
        t = base + $urandom_range(0, spread);
        if (t > 15) t = 15;
        sched[t][ch] = 1'b1;
      end
    end
    if ($urandom_range(0, 6) == 0) sched[$urandom_range(0, 15)][$urandom_range(0, 7)] = 1'b1;
  endtask

  // Reference: the event closes at the first t>=1 where every leaf has been
  // seen, else at TIMEOUT; only pulses at times 0..close are counted.
  task automatic run_event(input int hold, input bit extra_in);
    exp_t       e;
    logic [7:0] m;
    int         endt, first, last, c0;
    int         cnt[8];
    bit         found, done;
    m = sched[0];
    endt = TIMEOUT;
    found = 1'b0;
    for (int t = 1; t <= TIMEOUT; t++) begin
      m |= sched[t];
      if (!found && m == 8'hFF) begin
        endt = t;
        found = 1'b1;
      end
    end
    m = 8'h00;
    first = -1;
    last = -1;
    for (int ch = 0; ch < 8; ch++) cnt[ch] = 0;
    for (int t = 0; t <= endt; t++) begin
      m |= sched[t];
      if (sched[t] != 8'h00) begin
        if (first < 0) first = t;
        last = t;
      end
      for (int ch = 0; ch < 8; ch++) if (sched[t][ch]) cnt[ch]++;
    end
    e.mask = m;
    e.dup = 1'b0;
    for (int ch = 0; ch < 8; ch++) if (cnt[ch] >= 2) e.dup = 1'b1;
    e.skew = (first < 0) ? 0 : last - first;
    e.ok = (m == 8'hFF) && (e.skew <= MAX_SKEW) && !e.dup;

    @(posedge clk); #1;
    c0 = cyc;
    e.vcyc = c0 + endt + 1;
    q.push_back(e);
    in_pulse = 1'b1;
    out_pulse = sched[0];
    res_ready = 1'b0;
    for (int t = 1; t <= endt; t++) begin
      @(posedge clk); #1;
      in_pulse = extra_in && (t == 1);
      out_pulse = sched[t];
    end
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      in_pulse = 1'b0;
      out_pulse = 8'($urandom);
      res_ready = (k >= hold) && ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (res_valid && res_ready) done = 1'b1;
    end
    if (!done) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    out_pulse = 8'h00;
    res_ready = 1'b0;
  endtask

  // Scoreboard monitor: compares every presented result against the queue
  // front, checks the rise cycle, and tracks the expected error count.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      exp_err = 0;
    end else begin
      if (res_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!prev_v) chk("latency", cyc, q[0].vcyc);
          chk("res_mask", int'(res_mask), int'(q[0].mask));
          chk("res_skew", int'(res_skew), q[0].skew);
          chk("res_dup", int'(res_dup), int'(q[0].dup));
          chk("res_ok", int'(res_ok), int'(q[0].ok));
          if (res_ready) begin
            chk("err_count", int'(err_count), exp_err);
            if (!q[0].ok && exp_err < 255) exp_err++;
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && cyc > q[0].vcyc) begin
        chk("valid_late", 0, 1);
        void'(q.pop_front());
      end
      prev_v = res_valid;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_spurious", int'(spurious), 0);
    chk("rst_mask", int'(res_mask), 0);
    rst_n = 1'b1;

    // all leaves together at +3
    clear_sched(); sched[3] = 8'hFF; run_event(0, 1'b0);
    // two groups three cycles apart
    clear_sched(); sched[2] = 8'h0F; sched[5] = 8'hF0; run_event(0, 1'b0);
    // leaf 7 missing: timeout
    clear_sched(); sched[1] = 8'h7F; run_event(0, 1'b0);
    // leaf 2 twice, then held off for 5 cycles
    clear_sched(); sched[1] = 8'h04; sched[2] = 8'hFF; run_event(5, 1'b0);

    for (int n = 0; n < 150; n++) begin
      random_sched();
      run_event($urandom_range(0, 2), 1'b0);
    end
    chk("overrun_clear", int'(overrun), 0);
    chk("spurious_clear", int'(spurious), 0);

    // stray leaf strobe while idle
    @(posedge clk); #1; out_pulse = 8'h01;
    @(posedge clk); #1; out_pulse = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("spurious_set", int'(spurious), 1);
    chk("spurious_no_result", int'(res_valid), 0);

    // second root event during collection
    clear_sched(); sched[1] = 8'h0F; sched[4] = 8'hF0; run_event(0, 1'b1);
    chk("overrun_set", int'(overrun), 1);

    // reset in the middle of collection
    @(posedge clk); #1; in_pulse = 1'b1; out_pulse = 8'h03;
    @(posedge clk); #1; in_pulse = 1'b0; out_pulse = 8'h0C;
    @(posedge clk); #1; out_pulse = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(res_valid), 0);
    chk("arst_mask", int'(res_mask), 0);
    chk("arst_skew", int'(res_skew), 0);
    chk("arst_ok", int'(res_ok), 0);
    chk("arst_dup", int'(res_dup), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_spurious", int'(spurious), 0);
    chk("arst_err", int'(err_count), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    clear_sched(); sched[2] = 8'hFF; run_event(0, 1'b0);

    // fast failing events (duplicate on leaf 0) to saturate the counter
    for (int n = 0; n < 260; n++) begin
      clear_sched(); sched[0] = 8'hFF; sched[1] = 8'h01;
      run_event(0, 1'b0);
    end
    @(posedge clk); #1;
    chk("err_saturated", int'(err_count), 255);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
